ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: flush  input  1  abort in-flight operation (branch/jump redirect).
REQ-004 SHALL provide port: start  input  1  request new operation; sampled on rising edge.
REQ-005 SHALL provide port: op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL provide ports: operand_a, operand_b  input  32 each  rs1 and rs2 values from the ID/EX stage.
REQ-007 SHALL provide port: rd_in  input  5  destination register tag.
REQ-008 SHALL provide port: stall  output  1  combinational; holds upstream pipeline registers.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse; result and rd_out valid.
REQ-010 SHALL provide ports: result  output  32, and rd_out  output  5.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL accept start in IDLE or DONE: latch op, operands and rd_in; clear the 6-bit iteration counter; enter BUSY.
REQ-013 SHALL execute one radix-2 iteration per BUSY cycle: shift-add for multiply, restoring subtract for divide; exactly 32 iterations, then enter DONE.
REQ-014 SHALL assert done only in DONE, for exactly one cycle (33 cycles after the start edge), then return to IDLE unless start is high.
REQ-015 SHALL drive stall = (state==BUSY) | (start & state!=BUSY & ~flush); stall SHALL be 0 in the DONE cycle unless start is high.
REQ-016 SHALL compute signed and unsigned variants on magnitudes with sign fix-up; MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-017 SHALL return, on divide by zero: quotient 0xFFFFFFFF and remainder = operand_a, for both signed and unsigned ops.
REQ-018 SHALL return, for signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000 and remainder 0.
REQ-019 SHALL hold result and rd_out stable from DONE until the next DONE.
REQ-020 SHALL, on flush in any state, go to IDLE at the next edge; done stays 0; result and rd_out keep their prior values.
REQ-021 SHALL treat flush and start in the same cycle as flush: no operation is accepted.
REQ-022 SHALL ignore start while BUSY; the latched operands SHALL NOT change.

Reset
REQ-023 SHALL, on reset asserted, immediately force: state IDLE, counter 0, done 0, stall 0, result 0x00000000, rd_out 0, and all internal operand and accumulator registers 0.
REQ-024 SHALL, when reset is asserted mid-operation, discard the operation with no done pulse; the first start after deassertion behaves per REQ-012.

Configuration
REQ-025 SHALL support macro MULDIV_EARLY_OUT_EN.
REQ-026 SHALL, when MULDIV_EARLY_OUT_EN is defined, route the divide-by-zero case, the signed-overflow case and multiply-with-either-operand-zero from start straight to DONE; done follows 1 cycle after start.
REQ-027 SHALL, when MULDIV_EARLY_OUT_EN is undefined, always use 32 iterations; results SHALL be identical in both builds and only latency differs.

Verification
REQ-028 SHALL cover: MUL, a=7, b=-3 (0xFFFFFFFD) -> done at cycle 33, result 0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 SHALL cover: DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 SHALL cover: DIV a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5; DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0; done after 33 cycles (1 cycle with MULDIV_EARLY_OUT_EN).
REQ-031 SHALL cover: flush at BUSY cycle 10 -> IDLE next edge, no done, result unchanged; flush together with start -> stall 0, state stays IDLE.
REQ-032 SHALL cover: reset pulse at BUSY cycle 5 -> all outputs 0 immediately, no done; start after release -> correct result at cycle 33.
REQ-033 SHALL cover: back-to-back start in the DONE cycle -> done pulses 1 cycle, stall stays 1, second result is correct and rd_out updates.

Source files
------------

// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative RV32M multiply/divide unit for the EX stage. One
//            radix-2 step per BUSY cycle (shift-add multiply, restoring
//            divide) on operand magnitudes, 32 steps, sign fix-up at the end.
// Ports    : clk        in   rising-edge clock
//            reset      in   asynchronous, active-high reset
//            flush      in   abort any in-flight operation
//            start      in   request a new operation
//            op[2:0]    in   MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//            operand_a  in   rs1 value
//            operand_b  in   rs2 value
//            rd_in[4:0] in   destination register tag
//            stall      out  combinational hold for upstream registers
//            done       out  one-cycle pulse, result/rd_out valid
//            result     out  32-bit result, held until the next done
//            rd_out     out  destination tag of result
// Options  : MULDIV_EARLY_OUT_EN - divide-by-zero, signed overflow and
//            multiply-by-zero complete one cycle after start.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [2:0]  op_q,     op_d;
  logic [4:0]  rd_q,     rd_d;
  logic [31:0] mcand_q,  mcand_d;   // multiplicand or divisor magnitude
  logic [63:0] acc_q,    acc_d;     // {hi, multiplier} or {remainder, quotient}
  logic [31:0] a_raw_q,  a_raw_d;   // original rs1, the remainder on divide-by-zero
  logic        neg_q,    neg_d;     // negate the selected result half at the end
  logic        div0_q,   div0_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  // --------------------------------------------------------------------------
  // Operand preparation for a newly accepted operation
  // --------------------------------------------------------------------------
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_neg_res;

  always_comb begin
    w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    w_a_neg    = w_a_signed & operand_a[31];
    w_b_neg    = w_b_signed & operand_b[31];
    w_a_mag    = w_a_neg ? (32'd0 - operand_a) : operand_a;
    w_b_mag    = w_b_neg ? (32'd0 - operand_b) : operand_b;
    // MUL keeps only the low word, which is sign-agnostic, so it runs unsigned.
    // The remainder takes the sign of the dividend.
    case (op)
      OP_MULH, OP_DIV:   w_neg_res = w_a_neg ^ w_b_neg;
      OP_MULHSU, OP_REM: w_neg_res = w_a_neg;
      default:           w_neg_res = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Trivial-case short cut
  // --------------------------------------------------------------------------
  logic        w_early;
  logic [31:0] w_early_res;

`ifdef MULDIV_EARLY_OUT_EN
  logic w_b_zero;
  logic w_ovf;

  always_comb begin
    w_early     = 1'b0;
    w_early_res = 32'd0;
    w_b_zero    = (operand_b == 32'd0);
    w_ovf       = ((op == OP_DIV) || (op == OP_REM)) &&
                  (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    if (op[2]) begin
      // op[1] distinguishes remainder from quotient
      if (w_b_zero) begin
        w_early     = 1'b1;
        w_early_res = op[1] ? operand_a : 32'hFFFF_FFFF;
      end else if (w_ovf) begin
        w_early     = 1'b1;
        w_early_res = op[1] ? 32'd0 : 32'h8000_0000;
      end
    end else if ((operand_a == 32'd0) || w_b_zero) begin
      w_early     = 1'b1;
      w_early_res = 32'd0;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = 32'd0;
`endif

  // --------------------------------------------------------------------------
  // One radix-2 step and final sign fix-up
  // --------------------------------------------------------------------------
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_cand;
  logic [32:0] w_div_diff;
  logic        w_div_ok;
  logic [63:0] w_acc_step;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  always_comb begin
    // Multiply: add multiplicand into the high word when the multiplier LSB
    // is set, then shift the whole accumulator right (carry enters at bit 63).
    w_mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    // Divide: shift the next dividend bit into the partial remainder and try
    // a subtract; a clear borrow bit means the quotient bit is 1.
    w_div_cand = {acc_q[63:32], acc_q[31]};
    w_div_diff = w_div_cand - {1'b0, mcand_q};
    w_div_ok   = ~w_div_diff[32];

    if (op_q[2]) begin
      w_acc_step = {(w_div_ok ? w_div_diff[31:0] : w_div_cand[31:0]), acc_q[30:0], w_div_ok};
    end else begin
      w_acc_step = {w_mul_sum, acc_q[31:1]};
    end

    w_prod = neg_q ? (64'd0 - w_acc_step) : w_acc_step;
    w_quo  = neg_q ? (32'd0 - w_acc_step[31:0])  : w_acc_step[31:0];
    w_rem  = neg_q ? (32'd0 - w_acc_step[63:32]) : w_acc_step[63:32];

    case (op_q)
      OP_MUL:                       w_final = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[63:32];
      OP_DIV, OP_DIVU:              w_final = div0_q ? 32'hFFFF_FFFF : w_quo;
      OP_REM, OP_REMU:              w_final = div0_q ? a_raw_q : w_rem;
      default:                      w_final = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    a_raw_d  = a_raw_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    if (flush) begin
      // Flush wins over start; outputs keep their previous values.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_BUSY: begin
          // start is ignored here; latched operands stay untouched
          acc_d = w_acc_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d  = S_DONE;
            result_d = w_final;
            rd_out_d = rd_q;
          end
        end
        default: begin
          if (start) begin
            op_d    = op;
            rd_d    = rd_in;
            a_raw_d = operand_a;
            neg_d   = w_neg_res;
            div0_d  = op[2] & (operand_b == 32'd0);
            mcand_d = op[2] ? w_b_mag : w_a_mag;
            acc_d   = {32'd0, (op[2] ? w_a_mag : w_b_mag)};
            cnt_d   = 6'd0;
            if (w_early) begin
              state_d  = S_DONE;
              result_d = w_early_res;
              rd_out_d = rd_in;
            end else begin
              state_d = S_BUSY;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      mcand_q  <= 32'd0;
      acc_q    <= 64'd0;
      a_raw_q  <= 32'd0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      a_raw_q  <= a_raw_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Reset gates stall so it reads 0 even if start is held during reset.
  assign stall  = ~reset & ((state_q == S_BUSY) |
                            (start & (state_q != S_BUSY) & ~flush));
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Self-checking bench for ex_muldiv. Expected results are pushed
//            into a scoreboard queue at issue time; a monitor pops and checks
//            result, rd_out and latency whenever done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          cyc0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_done = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sbv;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      3'd0: begin t = ua * ub;               return t[31:0];  end
      3'd1: begin t = sa * sbv;              return t[63:32]; end
      3'd2: begin t = sa * longint'(ub);     return t[63:32]; end
      3'd3: begin t = ua * ub;               return t[63:32]; end
      3'd4: begin if (b == 0) t = '1; else t = sa / sbv;  return t[31:0]; end
      3'd5: begin if (b == 0) t = '1; else t = ua / ub;   return t[31:0]; end
      3'd6: begin if (b == 0) t = ua; else t = sa % sbv;  return t[31:0]; end
      default: begin if (b == 0) t = ua; else t = ua % ub; return t[31:0]; end
    endcase
  endfunction

  function automatic bit is_trivial(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    if (o[2])
      return (b == 32'd0) ||
             (((o == 3'd4) || (o == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    return (a == 32'd0) || (b == 32'd0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result 0x%08h rd %0d with nothing pending", result, rd_out);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_out", rd_out, e.rd);
        chk("latency", cyc - e.cyc0 + 1, e.lat);
      end
    end
  end

  // Called near a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input bit track);
    exp_t e;
    op        = o;
    operand_a = a;
    operand_b = b;
    rd_in     = rd;
    start     = 1'b1;
    if (track) begin
      e.res  = exp_res;
      e.rd   = rd;
      e.lat  = (EARLY_EN && is_trivial(o, a, b)) ? 1 : 33;
      e.cyc0 = cyc + 1;
      sb.push_back(e);
      last_res = exp_res;
      last_rd  = rd;
    end
    #1 chk("stall_on_start", stall, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within 80 cycles");
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_empty: %0d results still pending after 80 cycles", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    // Reset with start held high: every output must read 0.
    reset     = 1'b1;
    flush     = 1'b0;
    start     = 1'b1;
    op        = 3'd4;
    operand_a = 32'h1234;
    operand_b = 32'd3;
    rd_in     = 5'd7;
    last_res  = 32'd0;
    last_rd   = 5'd0;
    #3;
    chk("reset_stall",  stall,  0);
    chk("reset_done",   done,   0);
    chk("reset_result", result, 0);
    chk("reset_rd_out", rd_out, 0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed values with hand-computed expectations.
    issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1); wait_empty();
    issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1); wait_empty();
    issue(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFD, 1); wait_empty();
    issue(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF, 1); wait_empty();
    issue(3'd5, 32'd100,        32'd7,         5'd5,  32'd14,        1); wait_empty();
    issue(3'd7, 32'd100,        32'd7,         5'd6,  32'd2,         1); wait_empty();
    issue(3'd4, 32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF, 1); wait_empty();
    issue(3'd6, 32'd5,          32'd0,         5'd8,  32'd5,         1); wait_empty();
    issue(3'd4, 32'hFFFF_FFFB,  32'd0,         5'd9,  32'hFFFF_FFFF, 1); wait_empty();
    issue(3'd6, 32'hFFFF_FFFB,  32'd0,         5'd10, 32'hFFFF_FFFB, 1); wait_empty();
    issue(3'd7, 32'h1234_5678,  32'd0,         5'd11, 32'h1234_5678, 1); wait_empty();
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1); wait_empty();
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1); wait_empty();
    issue(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd14, 32'h4000_0000, 1); wait_empty();
    issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFF, 1); wait_empty();
    issue(3'd0, 32'd0,          32'd1234,      5'd16, 32'd0,         1); wait_empty();

    // Flush during the tenth BUSY cycle: back to idle, no done, outputs held.
    issue(3'd0, 32'd1234, 32'd5678, 5'd20, 32'd0, 0);
    nd = n_done;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle_stall", stall,  0);
    chk("flush_result",     result, last_res);
    chk("flush_rd_out",     rd_out, last_rd);

    // Flush together with start: nothing accepted.
    @(negedge clk);
    op        = 3'd5;
    operand_a = 32'd50;
    operand_b = 32'd3;
    rd_in     = 5'd21;
    start     = 1'b1;
    flush     = 1'b1;
    #1 chk("flush_start_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1 chk("flush_start_idle", stall, 0);
    repeat (40) @(negedge clk);
    chk("flush_no_done", n_done, nd);

    // Reset in the middle of an operation.
    issue(3'd5, 32'd1000, 32'd7, 5'd22, 32'd0, 0);
    nd = n_done;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_done",   done,   0);
    chk("midreset_stall",  stall,  0);
    chk("midreset_result", result, 0);
    chk("midreset_rd_out", rd_out, 0);
    last_res = 32'd0;
    last_rd  = 5'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_no_done", n_done, nd);
    issue(3'd5, 32'd1000, 32'd7, 5'd22, 32'd142, 1); wait_empty();

    // Back-to-back: second start issued in the DONE cycle.
    issue(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 1);
    wait_done();
    issue(3'd0, 32'd300, 32'd5, 5'd9, 32'd1500, 1);
    #1 chk("b2b_stall_busy", stall, 1);
    wait_empty();

    // Randomized operations, some issued back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(o, a, b, 5'($urandom), ref_model(o, a, b), 1);
      if ($urandom_range(0, 3) == 0) wait_done();
      else wait_empty();
    end
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
